// File: rtl/register_file_pkg.sv
// ============================================================================
// register_file_pkg : shared types and default sizes for the register file
// Revision: 1.0
// ============================================================================
`default_nettype none

package register_file_pkg;

   typedef enum logic [0:0] {
      RF_IDLE     = 1'b0,
      RF_CLEARING = 1'b1
   } rf_state_t;

   localparam int RF_DEFAULT_W     = 8;
   localparam int RF_DEFAULT_DEPTH = 8;

endpackage

`default_nettype wire

// File: rtl/register_file_read_port.sv
// ============================================================================
// register_file_read_port : one combinational read port with write bypass
// Revision: 1.0
// ============================================================================
`default_nettype none

module register_file_read_port
   import register_file_pkg::*;
#(
   parameter  int W        = RF_DEFAULT_W,
   parameter  int DEPTH    = RF_DEFAULT_DEPTH,
   parameter  int ZERO_REG = 0,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic [DEPTH*W-1:0] mem_flat_i,
   input  logic [DEPTH-1:0]   valid_i,
   input  logic [W-1:0]       wr_data_i,
   input  logic [AW-1:0]      wr_addr_i,
   input  logic               wr_en_i,
   input  logic               bypass_en_i,
   input  logic [AW-1:0]      rd_addr_i,
   output logic [W-1:0]       rd_data_o,
   output logic               rd_valid_o
);

   logic [W-1:0] w_entries [DEPTH];
   logic         w_zero_masked;
   logic         w_hit;

   for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
      assign w_entries[i] = mem_flat_i[i*W +: W];
   end

   assign w_zero_masked = (ZERO_REG != 0) && (rd_addr_i == '0);
   assign w_hit         = bypass_en_i && wr_en_i && (wr_addr_i == rd_addr_i) && !w_zero_masked;

   // A masked entry 0 wins over bypass: it always reads as a valid zero.
   always_comb begin
      rd_data_o  = w_entries[rd_addr_i];
      rd_valid_o = valid_i[rd_addr_i];
      if (w_zero_masked) begin
         rd_data_o  = '0;
         rd_valid_o = 1'b1;
      end else if (w_hit) begin
         rd_data_o  = wr_data_i;
         rd_valid_o = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/register_file_sb.sv
// ============================================================================
// register_file_sb : scoreboarded register file with sequential clear engine
// Revision: 1.0
// ============================================================================
`default_nettype none

module register_file_sb
   import register_file_pkg::*;
#(
   parameter  int W        = RF_DEFAULT_W,
   parameter  int DEPTH    = RF_DEFAULT_DEPTH,
   parameter  int ZERO_REG = 0,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          Reset_n,
   input  logic [W-1:0]  Data,
   input  logic [AW-1:0] Destination_Select,
   input  logic          Write_Enable,
   input  logic [AW-1:0] Source_Select_0,
   input  logic [AW-1:0] Source_Select_1,
   input  logic          Clear,
   output logic [W-1:0]  Out_0,
   output logic [W-1:0]  Out_1,
   output logic          Valid_0,
   output logic          Valid_1,
   output logic          Busy,
   output logic          Write_Error
);

   rf_state_t          state_q, state_d;
   logic [AW-1:0]      idx_q, idx_d;
   logic [W-1:0]       mem_q [DEPTH];
   logic [W-1:0]       mem_d [DEPTH];
   logic [DEPTH-1:0]   valid_q, valid_d;
   logic               werr_q, werr_d;
   logic               w_wr_accept;
   logic               w_idle;
   logic [DEPTH*W-1:0] w_mem_flat;

   assign w_idle      = (state_q == RF_IDLE);
   assign w_wr_accept = Write_Enable && !((ZERO_REG != 0) && (Destination_Select == '0));

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= RF_IDLE;
         idx_q   <= '0;
         valid_q <= '0;
         werr_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         werr_q  <= werr_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mem_d   = mem_q;
      valid_d = valid_q;
      werr_d  = (state_q == RF_CLEARING) && Write_Enable;
      case (state_q)
         RF_IDLE: begin
            // A write alongside Clear still lands; the sweep erases it later.
            if (w_wr_accept) begin
               mem_d[Destination_Select]   = Data;
               valid_d[Destination_Select] = 1'b1;
            end
            if (Clear) begin
               state_d = RF_CLEARING;
               idx_d   = '0;
            end
         end
         RF_CLEARING: begin
            mem_d[idx_q]   = '0;
            valid_d[idx_q] = 1'b0;
            if (idx_q == AW'(DEPTH - 1)) begin
               state_d = RF_IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: begin
            state_d = RF_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_flat
      assign w_mem_flat[i*W +: W] = mem_q[i];
   end

   register_file_read_port #(
      .W        (W),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
   ) u_rd0 (
      .mem_flat_i  (w_mem_flat),
      .valid_i     (valid_q),
      .wr_data_i   (Data),
      .wr_addr_i   (Destination_Select),
      .wr_en_i     (Write_Enable),
      .bypass_en_i (w_idle),
      .rd_addr_i   (Source_Select_0),
      .rd_data_o   (Out_0),
      .rd_valid_o  (Valid_0)
   );

   register_file_read_port #(
      .W        (W),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
   ) u_rd1 (
      .mem_flat_i  (w_mem_flat),
      .valid_i     (valid_q),
      .wr_data_i   (Data),
      .wr_addr_i   (Destination_Select),
      .wr_en_i     (Write_Enable),
      .bypass_en_i (w_idle),
      .rd_addr_i   (Source_Select_1),
      .rd_data_o   (Out_1),
      .rd_valid_o  (Valid_1)
   );

   assign Busy        = (state_q == RF_CLEARING);
   assign Write_Error = werr_q;

endmodule

`default_nettype wire

// File: tb/tb_register_file_sb.sv
// ============================================================================
// tb_register_file_sb : scoreboard bench; two DUTs (ZERO_REG=0 and =1) share stimulus
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_register_file_sb;

   localparam int W     = 8;
   localparam int DEPTH = 8;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  dat_d;
   logic [AW-1:0] wa_d, s0_d, s1_d;
   logic          we_d, clr_d;

   logic [1:0][W-1:0] out0, out1;
   logic [1:0]        val0, val1, busy, werr;

   typedef struct packed {
      logic [1:0][W-1:0] o0;
      logic [1:0][W-1:0] o1;
      logic [1:0]        v0;
      logic [1:0]        v1;
      logic              busy;
      logic              werr;
   } exp_t;

   exp_t q [$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: one storage image per DUT variant; pos < 0 means no sweep running
   logic [W-1:0] m_mem [2][DEPTH];
   logic         m_val [2][DEPTH];
   int           pos;
   logic         m_werr;

   always #5 clk = ~clk;

   register_file_sb #(.W(W), .DEPTH(DEPTH), .ZERO_REG(0)) dut (
      .CLK(clk), .Reset_n(rst_n), .Data(dat_d), .Destination_Select(wa_d),
      .Write_Enable(we_d), .Source_Select_0(s0_d), .Source_Select_1(s1_d),
      .Clear(clr_d), .Out_0(out0[0]), .Out_1(out1[0]), .Valid_0(val0[0]),
      .Valid_1(val1[0]), .Busy(busy[0]), .Write_Error(werr[0])
   );

   register_file_sb #(.W(W), .DEPTH(DEPTH), .ZERO_REG(1)) dut_z (
      .CLK(clk), .Reset_n(rst_n), .Data(dat_d), .Destination_Select(wa_d),
      .Write_Enable(we_d), .Source_Select_0(s0_d), .Source_Select_1(s1_d),
      .Clear(clr_d), .Out_0(out0[1]), .Out_1(out1[1]), .Valid_0(val0[1]),
      .Valid_1(val1[1]), .Busy(busy[1]), .Write_Error(werr[1])
   );

   function automatic void model_reset();
      for (int z = 0; z < 2; z++) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_mem[z][i] = '0;
            m_val[z][i] = 1'b0;
         end
      end
      pos    = -1;
      m_werr = 1'b0;
   endfunction

   function automatic logic [W:0] exp_rd(int z, logic [AW-1:0] a);
      if (z == 1 && a == 0) return {1'b1, {W{1'b0}}};
      if (pos < 0 && we_d && wa_d == a && !(z == 1 && wa_d == 0)) return {1'b1, dat_d};
      return {m_val[z][a], m_mem[z][a]};
   endfunction

   function automatic void model_edge();
      logic nxt_werr;
      nxt_werr = (pos >= 0) && we_d;
      if (pos >= 0) begin
         for (int z = 0; z < 2; z++) begin
            m_mem[z][pos] = '0;
            m_val[z][pos] = 1'b0;
         end
         pos++;
         if (pos == DEPTH) pos = -1;
      end else begin
         if (we_d) begin
            for (int z = 0; z < 2; z++) begin
               if (!(z == 1 && wa_d == 0)) begin
                  m_mem[z][wa_d] = dat_d;
                  m_val[z][wa_d] = 1'b1;
               end
            end
         end
         if (clr_d) pos = 0;
      end
      m_werr = nxt_werr;
   endfunction

   task automatic step(input logic rst, input logic we, input logic [AW-1:0] wa,
                       input logic [W-1:0] d, input logic [AW-1:0] s0,
                       input logic [AW-1:0] s1, input logic clr);
      exp_t       e;
      logic [W:0] r;
      @(posedge clk);
      #1;
      rst_n = !rst;
      we_d  = we;
      wa_d  = wa;
      dat_d = d;
      s0_d  = s0;
      s1_d  = s1;
      clr_d = clr;
      if (rst) model_reset();
      for (int z = 0; z < 2; z++) begin
         r       = exp_rd(z, s0);
         e.o0[z] = r[W-1:0];
         e.v0[z] = r[W];
         r       = exp_rd(z, s1);
         e.o1[z] = r[W-1:0];
         e.v1[z] = r[W];
      end
      e.busy = (pos >= 0);
      e.werr = m_werr;
      q.push_back(e);
      if (!rst) model_edge();
   endtask

   task automatic check(input string name, input int z, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, z, $time, act, req);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            for (int z = 0; z < 2; z++) begin
               check("out0",  z, 32'(out0[z]), 32'(e.o0[z]));
               check("val0",  z, 32'(val0[z]), 32'(e.v0[z]));
               check("out1",  z, 32'(out1[z]), 32'(e.o1[z]));
               check("val1",  z, 32'(val1[z]), 32'(e.v1[z]));
               check("busy",  z, 32'(busy[z]), 32'(e.busy));
               check("werr",  z, 32'(werr[z]), 32'(e.werr));
            end
         end
      end
   end

   initial begin : driver
      rst_n = 1'b0;
      we_d  = 1'b0;
      wa_d  = '0;
      dat_d = '0;
      s0_d  = '0;
      s1_d  = '0;
      clr_d = 1'b0;
      model_reset();

      step(1, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 2, 3, 0);
      for (int i = 0; i < DEPTH; i++)
         step(0, 0, 0, 0, AW'(i), AW'(DEPTH - 1 - i), 0);

      // Same-cycle bypass, then stored read; port 1 on an unwritten entry
      step(0, 1, 3, 8'hA5, 3, 4, 0);
      step(0, 0, 0, 8'h00, 3, 4, 0);
      // Entry 0 write: visible on the plain DUT, masked on the ZERO_REG DUT
      step(0, 1, 0, 8'hFF, 0, 0, 0);
      step(0, 0, 0, 8'h00, 0, 3, 0);

      for (int i = 0; i < DEPTH; i++)
         step(0, 1, AW'(i), W'(8'h10 + i), AW'(i), AW'(i), 0);
      step(0, 0, 0, 0, 0, 7, 1);
      for (int c = 0; c < DEPTH; c++)
         step(0, (c == 2), 5, 8'h77, AW'(c), AW'(c + DEPTH - 1), (c == 1));
      step(0, 0, 0, 0, 5, 7, 0);
      step(0, 1, 6, 8'h5A, 6, 5, 0);
      step(0, 0, 0, 0, 6, 0, 0);

      for (int i = 0; i < DEPTH; i++)
         step(0, 1, AW'(i), W'(8'h40 + i), AW'(i), 0, 0);
      step(0, 0, 0, 0, 1, 2, 1);
      for (int c = 0; c < 3; c++)
         step(0, 0, 0, 0, AW'(c), AW'(c + 4), 0);
      step(1, 0, 0, 0, 4, 5, 0);
      step(0, 1, 2, 8'h3C, 2, 6, 0);
      step(0, 0, 0, 0, 2, 7, 0);

      for (int n = 0; n < 400; n++)
         step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, DEPTH - 1)), W'($urandom),
              AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)),
              ($urandom_range(0, 15) == 0));

      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d required=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/register_file_sb.md
# register_file_sb

Parametrised, scoreboarded register file: DEPTH registers of W bits, one write port, two combinational read ports with same-cycle write bypass, and a per-entry valid bit. A Clear request starts a sequential clear engine that zeroes one entry per cycle while Busy is high. Serves as the datapath register file for the next-generation processor core, replacing the fixed 8-entry file.

## Interface
- W, 8, data width in bits (>=1)
- DEPTH, 8, number of entries (power of two, >=2); address width AW = $clog2(DEPTH), derived, not overridable
- ZERO_REG, 0, when 1, entry 0 is hardwired zero: writes to it are ignored, it reads 0, and its valid bit reads 1

- CLK  input  1  clock; all state updates on the rising edge
- Reset_n  input  1  asynchronous, active-low reset
- Data  input  W  write data
- Destination_Select  input  AW  write address
- Write_Enable  input  1  write strobe
- Source_Select_0  input  AW  read address, port 0
- Source_Select_1  input  AW  read address, port 1
- Clear  input  1  single-cycle request to clear all entries
- Out_0  output  W  read data, port 0
- Out_1  output  W  read data, port 1
- Valid_0  output  1  entry at Source_Select_0 was written since the last reset or clear
- Valid_1  output  1  same, port 1
- Busy  output  1  clear engine active
- Write_Error  output  1  registered one-cycle pulse: a write was dropped

## Operation
- Reset (Reset_n=0, asynchronous): all entries 0, all valid bits 0, FSM IDLE, clear index 0, Busy 0, Write_Error 0. Out_k and Valid_k then follow the combinational read rules.
- FSM states: IDLE, CLEARING. Busy = (state == CLEARING), registered.
- IDLE, Write_Enable=1: mem[Destination_Select] <= Data; valid <= 1. Exception: ZERO_REG=1 with address 0, where nothing changes and there is no error.
- IDLE, Clear=1: state <= CLEARING, index <= 0. A write in the same cycle is committed, then erased by the engine.
- CLEARING, each edge: mem[index] <= 0, valid[index] <= 0, index <= index+1. When index == DEPTH-1, state <= IDLE and index <= 0.
- CLEARING, Write_Enable=1: write dropped; Write_Error=1 on the following cycle.
- CLEARING, Clear=1: ignored. No restart, no error.
- Reads are combinational: Out_k = mem[Source_Select_k] and Valid_k = valid[Source_Select_k].
- Bypass, for each port independently: if state is IDLE, Write_Enable=1, Destination_Select == Source_Select_k, and the address is not a ZERO_REG-masked entry 0, then Out_k = Data and Valid_k = 1.
- Bypass is disabled in CLEARING. Reads in CLEARING return stored contents, so already-cleared entries read 0/0.
- Both ports may select the same address; both return identical values.
- Reset_n asserted mid-clear aborts the clear immediately; all state returns to reset values.

## Timing
- Write latency: Out_k reflects the new value in the same cycle via bypass, and from stored state from the cycle after the write edge.
- Clear sampled at edge t0:
  - Busy is high from t0 through edge t0+DEPTH, i.e. exactly DEPTH cycles.
  - Entry i is zeroed at edge t0+1+i.
  - Busy is low after edge t0+DEPTH.
  - The first accepted write is the one presented in the cycle after Busy falls.
- Write_Error goes high for one cycle, after the edge at which the dropped write was sampled.
- No combinational path from Clear to any output. There are combinational paths Data/Write_Enable/Destination_Select/Source_Select_k -> Out_k/Valid_k.

## Structure
- Shared package register_file_pkg:
  - rf_state_t enum {RF_IDLE, RF_CLEARING}
  - default W and DEPTH constants
- Sub-module register_file_read_port (params W, DEPTH, ZERO_REG), instantiated twice. It owns address decode, the ZERO_REG mask and the bypass compare. Inputs are flattened storage, the valid vector, the write bus and the bypass-enable signal.
- Top level holds the storage, the valid vector, the FSM/index counter and Write_Error.

## Test plan
- Reset then read: Reset_n low, then high; all addresses read -> Out=0, Valid=0, Busy=0, Write_Error=0.
- Write/bypass: W=8; write 0xA5 to address 3 with Source_Select_0=3 in the same cycle -> Out_0=0xA5, Valid_0=1 that cycle; next cycle with Write_Enable=0 -> still 0xA5/1. Source_Select_1=4 -> 0/0.
- ZERO_REG=1: write 0xFF to address 0 -> Out=0 and Valid=1 both in the same cycle and after; no Write_Error.
- Clear sweep: DEPTH=8, all entries written with 0x10+i; pulse Clear.
  - Busy is high for exactly 8 cycles.
  - Entry i reads 0/0 from the cycle after edge t0+1+i; entries not yet cleared still read 0x10+i.
  - A second Clear during the sweep does not extend Busy.
- Write during clear: Write_Enable with 0x77 to address 5 in the 3rd Busy cycle -> Write_Error is a one-cycle pulse next cycle; address 5 reads 0 after the sweep.
- Async abort: Reset_n pulsed low in the 4th Busy cycle, not aligned to CLK -> Busy falls immediately and all entries read 0/0. A write right after Reset_n releases succeeds.
